// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, data) in front of a single-port memory with LAT-cycle read latency.
// Optional fetch starvation guard enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_t      state_q, state_d;
    logic        id_q, id_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d;

    logic        rvalid_w;
    logic        free_w;
    logic        fetch_first_w;
    logic        d_win_w;
    logic        f_win_w;

    // The rvalid cycle doubles as an arbitration cycle, so back-to-back reads lose no cycle.
    always_comb begin
        rvalid_w = (state_q == BUSY) && (lat_q == LAT_CNT) && !rst;
        free_w   = (state_q == IDLE) || rvalid_w;
        d_win_w  = free_w && !rst && d_req && !(if_req && fetch_first_w);
        f_win_w  = free_w && !rst && if_req && !d_win_w;
    end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (free_w) begin
            if (f_win_w || !if_req) begin
                starve_d = 4'd0;
            end else if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign fetch_first_w = (starve_q >= STARVE_LIM);
`else
    assign fetch_first_w = 1'b0;
`endif

    always_comb begin
        if ((state_q == BUSY) && !rvalid_w) begin
            mem_addr = addr_q;
        end else if (d_win_w) begin
            mem_addr = d_addr;
        end else begin
            mem_addr = if_addr;
        end
        mem_we    = d_win_w && d_we;
        mem_wdata = d_wdata;
        if_gnt    = f_win_w;
        d_gnt     = d_win_w;
        if_rvalid = rvalid_w && !id_q;
        d_rvalid  = rvalid_w && id_q;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        if (rvalid_w) begin
            state_d = IDLE;
        end else if (state_q == BUSY) begin
            lat_d = lat_q + 3'd1;
        end
        if ((d_win_w && !d_we) || f_win_w) begin
            state_d = BUSY;
            id_d    = d_win_w;
            lat_d   = 3'd1;
            addr_d  = mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            lat_q   <= lat_d;
        end
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=1 and a LAT=3 instance share one stimulus set.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_we3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    logic [31:0] a1_p;
    logic [31:0] a3_p0, a3_p1, a3_p2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        a1_p  <= mem_addr1;
        a3_p0 <= mem_addr3;
        a3_p1 <= a3_p0;
        a3_p2 <= a3_p1;
    end
    assign mem_rdata1 = memval(a1_p);
    assign mem_rdata3 = memval(a3_p2);

    mem_arbiter #(.LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    mem_arbiter #(.LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (6) next();
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h0;
        next();
        @(negedge clk);
        total++; if ({if_gnt1, d_gnt1, if_rvalid1, d_rvalid1, mem_we1} !== 5'b0)
            begin bad++; $display("FAIL reset_out1 got=%b want=00000", {if_gnt1, d_gnt1, if_rvalid1, d_rvalid1, mem_we1}); end
        total++; if ({if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, mem_we3} !== 5'b0)
            begin bad++; $display("FAIL reset_out3 got=%b want=00000", {if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, mem_we3}); end
        next();
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        total++; if (if_gnt1 !== 1'b1)
            begin bad++; $display("FAIL first_gnt got=%b want=1", if_gnt1); end
        next();
        settle();
    endtask

    task automatic test_fetch_read();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        total++; if (if_gnt1 !== 1'b1 || d_gnt1 !== 1'b0 || mem_addr1 !== 32'h10)
            begin bad++; $display("FAIL fetch_gnt gnt=%b dgnt=%b addr=%h want 1 0 10", if_gnt1, d_gnt1, mem_addr1); end
        next();
        if_req = 1'b0;
        @(negedge clk);
        total++; if (if_rvalid1 !== 1'b1 || if_rdata1 !== memval(32'h10))
            begin bad++; $display("FAIL fetch_rvalid v=%b data=%h want 1 %h", if_rvalid1, if_rdata1, memval(32'h10)); end
        next();
        @(negedge clk);
        total++; if (if_rvalid1 !== 1'b0)
            begin bad++; $display("FAIL fetch_rvalid_pulse got=%b want=0", if_rvalid1); end
        settle();
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        @(negedge clk);
        total++; if (d_gnt1 !== 1'b1 || if_gnt1 !== 1'b0 || mem_addr1 !== 32'h40)
            begin bad++; $display("FAIL prio_gnt dgnt=%b ignt=%b addr=%h want 1 0 40", d_gnt1, if_gnt1, mem_addr1); end
        next();
        d_req = 1'b0;
        @(negedge clk);
        total++; if (d_rvalid1 !== 1'b1 || d_rdata1 !== memval(32'h40))
            begin bad++; $display("FAIL prio_drvalid v=%b data=%h want 1 %h", d_rvalid1, d_rdata1, memval(32'h40)); end
        total++; if (if_gnt1 !== 1'b1 || mem_addr1 !== 32'h10 || if_rvalid1 !== 1'b0)
            begin bad++; $display("FAIL prio_fetch_same_cycle gnt=%b addr=%h irv=%b want 1 10 0", if_gnt1, mem_addr1, if_rvalid1); end
        next();
        if_req = 1'b0;
        @(negedge clk);
        total++; if (if_rvalid1 !== 1'b1 || if_rdata1 !== memval(32'h10) || d_rvalid1 !== 1'b0)
            begin bad++; $display("FAIL prio_irvalid v=%b data=%h drv=%b want 1 %h 0", if_rvalid1, if_rdata1, d_rvalid1, memval(32'h10)); end
        settle();
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (d_gnt1 !== 1'b1 || mem_we1 !== 1'b1 || mem_addr1 !== 32'h20 || mem_wdata1 !== 32'hDEADBEEF)
            begin bad++; $display("FAIL write_cycle gnt=%b we=%b addr=%h wd=%h want 1 1 20 deadbeef", d_gnt1, mem_we1, mem_addr1, mem_wdata1); end
        next();
        d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        total++; if (mem_we1 !== 1'b0 || d_rvalid1 !== 1'b0 || if_gnt1 !== 1'b1 || mem_addr1 !== 32'h30)
            begin bad++; $display("FAIL write_next we=%b drv=%b ignt=%b addr=%h want 0 0 1 30", mem_we1, d_rvalid1, if_gnt1, mem_addr1); end
        next();
        if_req = 1'b0;
        @(negedge clk);
        total++; if (if_rvalid1 !== 1'b1 || d_rvalid1 !== 1'b0)
            begin bad++; $display("FAIL write_after irv=%b drv=%b want 1 0", if_rvalid1, d_rvalid1); end
        settle();
    endtask

    task automatic test_lat3();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        total++; if (d_gnt3 !== 1'b1 || if_gnt3 !== 1'b0)
            begin bad++; $display("FAIL lat3_gnt dgnt=%b ignt=%b want 1 0", d_gnt3, if_gnt3); end
        next();
        d_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            total++; if ({if_gnt3, d_gnt3, d_rvalid3, if_rvalid3, mem_we3} !== 5'b0 || mem_addr3 !== 32'h44)
                begin bad++; $display("FAIL lat3_busy c=%0d flags=%b addr=%h want 00000 44", c, {if_gnt3, d_gnt3, d_rvalid3, if_rvalid3, mem_we3}, mem_addr3); end
            next();
        end
        @(negedge clk);
        total++; if (d_rvalid3 !== 1'b1 || d_rdata3 !== memval(32'h44) || if_gnt3 !== 1'b1)
            begin bad++; $display("FAIL lat3_rvalid v=%b data=%h ignt=%b want 1 %h 1", d_rvalid3, d_rdata3, if_gnt3, memval(32'h44)); end
        next();
        if_req = 1'b0;
        @(negedge clk);
        total++; if (d_rvalid3 !== 1'b0)
            begin bad++; $display("FAIL lat3_pulse got=%b want=0", d_rvalid3); end
        settle();
    endtask

    task automatic test_reset_abort();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
        @(negedge clk);
        total++; if (d_gnt3 !== 1'b1)
            begin bad++; $display("FAIL abort_gnt got=%b want=1", d_gnt3); end
        next();
        d_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if ({if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, mem_we3} !== 5'b0)
            begin bad++; $display("FAIL abort_rst_out got=%b want=00000", {if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, mem_we3}); end
        next();
        rst = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            total++; if (d_rvalid3 !== 1'b0 || if_rvalid3 !== 1'b0)
                begin bad++; $display("FAIL abort_no_rvalid c=%0d drv=%b irv=%b want 0 0", c, d_rvalid3, if_rvalid3); end
            next();
        end
        settle();
    endtask

    task automatic test_starve();
        bit guard;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        if_req = 1'b1; if_addr = 32'h50; d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h1234_5678;
        for (int c = 0; c < (guard ? 5 : 8); c++) begin
            logic exp_if;
            d_addr = 32'h100 + 32'(c * 4);
            exp_if = guard && (c == 4);
            @(negedge clk);
            total++; if (if_gnt1 !== exp_if || d_gnt1 !== !exp_if)
                begin bad++; $display("FAIL starve c=%0d ignt=%b dgnt=%b want %b %b", c, if_gnt1, d_gnt1, exp_if, !exp_if); end
            next();
        end
        settle();
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        next();
        test_reset();
        test_fetch_read();
        test_priority();
        test_write();
        test_lat3();
        test_reset_abort();
        test_starve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
